mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the pipeline: consumes the EX/MEM register outputs, performs byte-serial loads/stores over the shared 8-bit RAM port, and loads the MEM/WB register. It holds the EX/MEM register via `stall_req` while an access is in flight. It then presents the sign- or zero-extended load result, or passes non-memory results through, to write-back.

## Interface
Parameters:
- none. Widths are fixed: register address 5, data/address/instruction 32.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `in_wd`  in  5  destination register
- `in_wreg`  in  1  register write enable
- `in_wdata`  in  32  ALU result (non-mem) or store data (store)
- `in_memaddr`  in  32  byte address
- `in_memwr`  in  1  0 = load, 1 = store
- `in_memcnf`  in  2  0 = none, 1 = B, 2 = H, 3 = W
- `in_memsigned`  in  1  sign-extend load
- `in_inst`  in  32  instruction word (debug/trace)
- `ram_req`  out  1  byte access requested this cycle
- `ram_gnt`  in  1  arbiter grants the requested byte this cycle
- `ram_a`  out  32  byte address
- `ram_wr`  out  1  1 = write byte
- `ram_dout`  out  8  write byte
- `ram_din`  in  8  read byte, valid the cycle after a granted read
- `stall_req`  out  1  hold EX/MEM register
- `wb_wd`, `wb_wreg`, `wb_wdata`, `wb_inst`  out  5/1/32/32  MEM/WB register
- `misalign`  out  1  misaligned access flag (only with macro)

## Operation
- States: IDLE, ACCESS, FINISH. Byte count N = 1/2/4 for cnf 1/2/3.
- IDLE, `in_memcnf == 0`:
  - `stall_req = 0`
  - wb regs load `in_wd`/`in_wreg`/`in_wdata`/`in_inst`
  - stay in IDLE
- IDLE, `in_memcnf != 0`:
  - `stall_req = 1`
  - wb regs load a bubble (`wb_wreg = 0`, others 0)
  - clear counters `issued = 0`, `recvd = 0`
  - go to ACCESS
- ACCESS, request side:
  - `stall_req = 1`, wb regs load a bubble
  - while `issued < N`: `ram_req = 1`, `ram_a = in_memaddr + issued`, `ram_wr = in_memwr`, `ram_dout = in_wdata[8*issued+7 : 8*issued]`
  - on `ram_gnt`: `issued += 1`
  - without `ram_gnt`: hold request and address unchanged (retry)
- ACCESS, load return:
  - flag `rd_pend` registers (`ram_gnt & ~ram_wr`)
  - when `rd_pend` is set: byte `recvd` of the assembly buffer ← `ram_din`, `recvd += 1`
- ACCESS exit:
  - store: `issued == N`
  - load: `recvd == N`
  - exit goes to FINISH
- FINISH:
  - `stall_req = 0`, `ram_req = 0`
  - wb regs load `in_wd`, `in_inst`; `wb_wreg = in_wreg & ~in_memwr`
  - `wb_wdata`: load → buffer extended to 32 bits (sign bit = bit 8N-1 when `in_memsigned`, else zero); store → 0
  - go to IDLE; EX/MEM advances on the same edge
- Address arithmetic is 32-bit modulo; wrap past 0xFFFFFFFF goes to 0.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, `rd_pend` 0.
- Reset mid-access aborts immediately; no further `ram_req`.
- `stall_req` and `ram_*` are combinational from state, counters and `in_*`. The wb regs and `misalign` are registered.
- Non-mem latency: wb valid 1 cycle after the input appears; no stall.
- Store with continuous grant: 1 (IDLE) + N (ACCESS) + 1 (FINISH) cycles.
- Load with continuous grant: 1 + N + 1 (ACCESS, the last data byte is captured in the extra ACCESS cycle) + 1 (FINISH) cycles.
- Grant gaps extend ACCESS one cycle per denied request. A read byte arrives exactly 1 cycle after its grant regardless of later gaps.
- `ram_gnt` while `ram_req = 0` is ignored.
- Inputs are assumed stable while `stall_req = 1`.

## Configuration
- `MEM_ALIGN_CHECK_EN`:
  - defined: in IDLE, H with `addr[0] != 0` or W with `addr[1:0] != 0` skips ACCESS and goes to FINISH. There, `misalign = 1` for one cycle, `wb_wreg = 0`, and no RAM request is issued.
  - undefined: no check; bytes `addr .. addr+N-1` are accessed; `misalign` is tied to 0.

## Test plan
- Non-mem pass-through: `in_memcnf = 0`, `wd = 5`, `wdata = 0x1234` → next cycle `wb_wd = 5`, `wb_wdata = 0x1234`, `wb_wreg = 1`; `stall_req` never high.
- Store word: addr 0x100, data 0xAABBCCDD, grant always → writes 0xDD@0x100, 0xCC@0x101, 0xBB@0x102, 0xAA@0x103 on consecutive cycles; `stall_req` high for 5 cycles; `wb_wreg = 0`.
- Load signed byte: RAM[0x20] = 0x80, `memsigned = 1` → `wb_wdata = 0xFFFFFF80`. With `memsigned = 0` → `0x00000080`.
- Load half with grant denied on the 2nd byte for 3 cycles: RAM[0x40..41] = 0x34, 0x12 → `ram_a` holds 0x41 during the denial; result `0x00001234`; stall lasts 3 cycles longer than the no-gap case.
- Reset asserted in the 2nd ACCESS cycle of a word load → next cycle `ram_req = 0`, `stall_req = 0`, wb regs 0, state IDLE; the following load completes normally.
- With `MEM_ALIGN_CHECK_EN`: word load at 0x102 → no `ram_req`; `misalign = 1` for one cycle; `wb_wreg = 0`.

Source files
------------

// File: rtl/mem_access_if.sv
// -----------------------------------------------------------------------------
// mem_access_if
//
// Byte-serial bus between the memory-access pipeline stage and the shared
// 8-bit RAM port / arbiter.
//
// Signals:
//   ram_req   requester -> RAM   byte access requested this cycle
//   ram_gnt   RAM -> requester   arbiter grants the requested byte this cycle
//   ram_a     requester -> RAM   byte address (32 bit)
//   ram_wr    requester -> RAM   1 = write byte, 0 = read byte
//   ram_dout  requester -> RAM   write byte
//   ram_din   RAM -> requester   read byte, valid the cycle after a granted read
//
// Modports:
//   master  the pipeline stage (drives request, address, write data)
//   slave   the RAM / arbiter side (drives grant and read data)
// -----------------------------------------------------------------------------
interface mem_access_if;
    logic        ram_req;
    logic        ram_gnt;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    modport master (
        output ram_req,
        output ram_a,
        output ram_wr,
        output ram_dout,
        input  ram_gnt,
        input  ram_din
    );

    modport slave (
        input  ram_req,
        input  ram_a,
        input  ram_wr,
        input  ram_dout,
        output ram_gnt,
        output ram_din
    );
endinterface

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access stage of the pipeline. Consumes the EX/MEM register outputs,
// performs byte-serial loads and stores over the shared 8-bit RAM port and
// loads the MEM/WB register. While an access is in flight the EX/MEM register
// is held through stall_req. Loads are assembled little-endian (byte 0 at the
// lowest address) and sign- or zero-extended to 32 bits; non-memory results
// pass straight through with one cycle of latency.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_wd           destination register (5)
//   in_wreg         register write enable
//   in_wdata        ALU result (non-mem) or store data (store) (32)
//   in_memaddr      byte address (32)
//   in_memwr        0 = load, 1 = store
//   in_memcnf       0 = none, 1 = byte, 2 = half, 3 = word
//   in_memsigned    sign-extend load result
//   in_inst         instruction word, forwarded for trace (32)
//   ram             byte-serial RAM bus (mem_access_if.master)
//   stall_req       hold EX/MEM register
//   wb_wd/wb_wreg/wb_wdata/wb_inst   MEM/WB register outputs
//   misalign        misaligned-access flag, one cycle, registered
//
// Configuration macro:
//   MEM_ALIGN_CHECK_EN  when defined, a half access at an odd address or a
//                       word access at an address not a multiple of 4 issues
//                       no RAM request, suppresses the register write and
//                       pulses misalign. When undefined the bytes
//                       addr .. addr+N-1 are accessed and misalign is 0.
// -----------------------------------------------------------------------------
module mem_access (
    input  logic               clk,
    input  logic               rst,

    input  logic [4:0]         in_wd,
    input  logic               in_wreg,
    input  logic [31:0]        in_wdata,
    input  logic [31:0]        in_memaddr,
    input  logic               in_memwr,
    input  logic [1:0]         in_memcnf,
    input  logic               in_memsigned,
    input  logic [31:0]        in_inst,

    mem_access_if.master       ram,

    output logic               stall_req,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [31:0]        wb_wdata,
    output logic [31:0]        wb_inst,
    output logic               misalign
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;

    // Bytes requested-and-granted, and read bytes returned, in this access.
    logic [2:0]  issued_reg;
    logic [2:0]  issued_next;
    logic [2:0]  recvd_reg;
    logic [2:0]  recvd_next;

    // A read was granted last cycle, so ram_din carries its byte now.
    logic        rd_pend_reg;

    // Set in IDLE when the access was rejected as misaligned; it selects the
    // suppressed write-back in FINISH.
    logic        mis_pend_reg;
    logic        mis_now;

    logic [7:0]  buf_reg [4];

    logic [2:0]  n_bytes;
    logic        req_active;
    logic        req_fire;
    logic        capture_en;
    logic [31:0] load_ext;

    logic [4:0]  wb_wd_reg;
    logic        wb_wreg_reg;
    logic [31:0] wb_wdata_reg;
    logic [31:0] wb_inst_reg;

    // -------------------------------------------------------------------------
    // Access size decode
    // -------------------------------------------------------------------------
    always_comb begin
        case (in_memcnf)
            2'd1:    n_bytes = 3'd1;
            2'd2:    n_bytes = 3'd2;
            2'd3:    n_bytes = 3'd4;
            default: n_bytes = 3'd0;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_now = ((in_memcnf == 2'd2) && in_memaddr[0]) ||
                     ((in_memcnf == 2'd3) && (in_memaddr[1:0] != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // RAM request side. Everything is combinational from the state, the
    // counters and the held EX/MEM inputs; a denied request simply re-presents
    // the same byte next cycle because issued_reg does not move. Reset gates
    // the request so an abort takes effect in the reset cycle itself.
    // -------------------------------------------------------------------------
    assign req_active = ~rst && (state_reg == ST_ACCESS) && (issued_reg < n_bytes);
    assign req_fire   = req_active & ram.ram_gnt;

    assign ram.ram_req  = req_active;
    assign ram.ram_a    = req_active ? (in_memaddr + {29'd0, issued_reg}) : 32'd0;
    assign ram.ram_wr   = req_active & in_memwr;
    assign ram.ram_dout = req_active ? in_wdata[{issued_reg[1:0], 3'b000} +: 8] : 8'd0;

    // The IDLE cycle of a memory op already stalls: EX/MEM must not advance
    // until FINISH, where the result for the held instruction is produced.
    assign stall_req = ~rst && (((state_reg == ST_IDLE) && (in_memcnf != 2'd0)) ||
                                (state_reg == ST_ACCESS));

    // -------------------------------------------------------------------------
    // Next-state and counter logic. The ACCESS exit looks at the counter
    // values after this cycle's grant/return so that the transition happens
    // on the same edge as the last store grant or the last read byte.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        issued_next = issued_reg;
        recvd_next  = recvd_reg;

        case (state_reg)
            ST_IDLE: begin
                issued_next = 3'd0;
                recvd_next  = 3'd0;
                if (in_memcnf != 2'd0) begin
                    state_next = mis_now ? ST_FINISH : ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                issued_next = issued_reg + {2'd0, req_fire};
                if (capture_en) begin
                    recvd_next = recvd_reg + 3'd1;
                end
                if (in_memwr ? (issued_next == n_bytes) : (recvd_next == n_bytes)) begin
                    state_next = ST_FINISH;
                end
            end

            ST_FINISH: begin
                issued_next = 3'd0;
                recvd_next  = 3'd0;
                state_next  = ST_IDLE;
            end

            default: begin
                issued_next = 3'd0;
                recvd_next  = 3'd0;
                state_next  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            issued_reg  <= 3'd0;
            recvd_reg   <= 3'd0;
            rd_pend_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            issued_reg  <= issued_next;
            recvd_reg   <= recvd_next;
            rd_pend_reg <= req_fire & ~in_memwr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_pend_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            mis_pend_reg <= mis_now;
        end
    end

    // -------------------------------------------------------------------------
    // Load assembly buffer: the returned byte lands in the lane selected by
    // the receive counter, so byte k of the result comes from address addr+k.
    // -------------------------------------------------------------------------
    assign capture_en = (state_reg == ST_ACCESS) && rd_pend_reg && (recvd_reg < n_bytes);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg[gi] <= 8'd0;
                end else if (capture_en && (recvd_reg[1:0] == 2'(gi))) begin
                    buf_reg[gi] <= ram.ram_din;
                end
            end
        end
    endgenerate

    // Extension takes its sign from the top byte actually loaded.
    always_comb begin
        case (in_memcnf)
            2'd1:    load_ext = {{24{in_memsigned & buf_reg[0][7]}}, buf_reg[0]};
            2'd2:    load_ext = {{16{in_memsigned & buf_reg[1][7]}}, buf_reg[1], buf_reg[0]};
            default: load_ext = {buf_reg[3], buf_reg[2], buf_reg[1], buf_reg[0]};
        endcase
    end

    // -------------------------------------------------------------------------
    // MEM/WB register. A memory op shows bubbles while it is in progress and
    // its real result only on the FINISH edge, which is also the edge on
    // which EX/MEM advances.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_reg    <= 5'd0;
            wb_wreg_reg  <= 1'b0;
            wb_wdata_reg <= 32'd0;
            wb_inst_reg  <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_memcnf == 2'd0) begin
                        wb_wd_reg    <= in_wd;
                        wb_wreg_reg  <= in_wreg;
                        wb_wdata_reg <= in_wdata;
                        wb_inst_reg  <= in_inst;
                    end else begin
                        wb_wd_reg    <= 5'd0;
                        wb_wreg_reg  <= 1'b0;
                        wb_wdata_reg <= 32'd0;
                        wb_inst_reg  <= 32'd0;
                    end
                end

                ST_FINISH: begin
                    wb_wd_reg    <= in_wd;
                    wb_inst_reg  <= in_inst;
                    wb_wreg_reg  <= in_wreg & ~in_memwr & ~mis_pend_reg;
                    wb_wdata_reg <= (in_memwr | mis_pend_reg) ? 32'd0 : load_ext;
                end

                default: begin
                    wb_wd_reg    <= 5'd0;
                    wb_wreg_reg  <= 1'b0;
                    wb_wdata_reg <= 32'd0;
                    wb_inst_reg  <= 32'd0;
                end
            endcase
        end
    end

    assign wb_wd    = wb_wd_reg;
    assign wb_wreg  = wb_wreg_reg;
    assign wb_wdata = wb_wdata_reg;
    assign wb_inst  = wb_inst_reg;

`ifdef MEM_ALIGN_CHECK_EN
    // Registered alongside the suppressed write-back so both appear together.
    logic misalign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= (state_reg == ST_FINISH) && mis_pend_reg;
        end
    end

    assign misalign = misalign_reg;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Self-checking bench for mem_access. A byte-addressed associative array
// models the RAM; loads are predicted by summing bytes little-endian and
// extending arithmetically, stores update the array on every grant. A
// responder returns read data one cycle after each granted read and drives
// random grants (including grants while no request is pending).
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic [31:0] in_memaddr;
    logic        in_memwr;
    logic [1:0]  in_memcnf;
    logic        in_memsigned;
    logic [31:0] in_inst;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_inst;
    logic        misalign;

    mem_access_if bus ();

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .in_wd        (in_wd),
        .in_wreg      (in_wreg),
        .in_wdata     (in_wdata),
        .in_memaddr   (in_memaddr),
        .in_memwr     (in_memwr),
        .in_memcnf    (in_memcnf),
        .in_memsigned (in_memsigned),
        .in_inst      (in_inst),
        .ram          (bus.master),
        .stall_req    (stall_req),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .wb_inst      (wb_inst),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_model [logic [31:0]];
    logic        rd_pend_tb = 1'b0;
    logic [31:0] rd_addr_tb = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = 8'($urandom);
        return mem_model[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one EX/MEM instruction from its first cycle until the MEM/WB
    // register holds its result, then checks that result.
    // gnt_mode 0: grant every request; 1: random grants.
    // Request index deny_idx is refused the first deny_len times it is seen.
    task automatic run_txn(input logic [1:0] cnf, input logic wr, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] wd, input logic wreg,
                           input int gnt_mode, input int deny_idx, input int deny_len);
        int          n;
        int          k;
        int          stall_cyc;
        int          denied;
        int          deny_seen;
        int          cyc;
        int          exp_stall;
        bit          done;
        bit          mis;
        logic        g;
        logic [31:0] exp_val;
        logic [31:0] inst;

        n    = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : (cnf == 2'd3) ? 4 : 0;
        mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis  = ((cnf == 2'd2) && addr[0]) || ((cnf == 2'd3) && (addr[1:0] != 2'b00));
`endif
        inst = $urandom;

        // Expected load value from the memory image before the access.
        exp_val = 32'd0;
        if (!wr && n > 0) begin
            for (int i = 0; i < n; i++) exp_val = exp_val + (32'(mem_rd(addr + 32'(i))) << (8 * i));
            if (sgn && n < 4 && exp_val[8 * n - 1]) exp_val = exp_val | (32'hFFFF_FFFF << (8 * n));
        end

        in_memcnf    = cnf;
        in_memwr     = wr;
        in_memsigned = sgn;
        in_memaddr   = addr;
        in_wdata     = wdata;
        in_wd        = wd;
        in_wreg      = wreg;
        in_inst      = inst;

        k = 0; stall_cyc = 0; denied = 0; deny_seen = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            bus.ram_din = rd_pend_tb ? mem_rd(rd_addr_tb) : 8'($urandom);
            if (stall_req) stall_cyc++;
            else done = 1'b1;
            g = 1'b0;
            if (bus.ram_req) begin
                if (k >= n || mis || cnf == 2'd0) begin
                    check_val("extra_req", 32'(bus.ram_req), 32'd0);
                end else begin
                    check_val("ram_a", bus.ram_a, addr + 32'(k));
                    check_val("ram_wr", 32'(bus.ram_wr), 32'(wr));
                    if (wr) check_val("ram_dout", 32'(bus.ram_dout), 32'(8'(wdata >> (8 * k))));
                    if (k == deny_idx && deny_seen < deny_len) begin
                        g = 1'b0;
                        deny_seen++;
                    end else if (gnt_mode == 1) begin
                        g = ($urandom_range(0, 3) != 0);
                    end else begin
                        g = 1'b1;
                    end
                    if (g) begin
                        if (wr) mem_model[addr + 32'(k)] = 8'(wdata >> (8 * k));
                        rd_addr_tb = addr + 32'(k);
                        k++;
                    end else begin
                        denied++;
                    end
                end
                rd_pend_tb = g && !wr;
            end else begin
                rd_pend_tb = 1'b0;
                g = (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.ram_gnt = g;
            tick();
            cyc++;
        end
        if (!done) check_val("timeout", 32'(stall_req), 32'd0);

        if (cnf == 2'd0)  exp_stall = 0;
        else if (mis)     exp_stall = 1;
        else              exp_stall = 1 + n + denied + (wr ? 0 : 1);
        check_val("stall_cycles", 32'(stall_cyc), 32'(exp_stall));
        check_val("bytes_done", 32'(k), mis ? 32'd0 : 32'(n));

        #1;
        check_val("wb_wd", 32'(wb_wd), 32'(wd));
        check_val("wb_inst", wb_inst, inst);
        if (cnf == 2'd0) begin
            check_val("wb_wreg", 32'(wb_wreg), 32'(wreg));
            check_val("wb_wdata", wb_wdata, wdata);
        end else begin
            check_val("wb_wreg", 32'(wb_wreg), 32'(wreg & !wr & !mis));
            check_val("wb_wdata", wb_wdata, (wr || mis) ? 32'd0 : exp_val);
        end
        check_val("misalign", 32'(misalign), 32'(mis));
        $display("txn cnf=%0d wr=%0d sgn=%0d addr=%h wdata=%h denied=%0d stall=%0d wb_wreg=%0d wb_wdata=%h",
                 cnf, wr, sgn, addr, wdata, denied, stall_cyc, wb_wreg, wb_wdata);
    endtask

    initial begin
        rst          = 1'b1;
        in_wd        = 5'd0;
        in_wreg      = 1'b0;
        in_wdata     = 32'd0;
        in_memaddr   = 32'd0;
        in_memwr     = 1'b0;
        in_memcnf    = 2'd0;
        in_memsigned = 1'b0;
        in_inst      = 32'd0;
        bus.ram_gnt  = 1'b0;
        bus.ram_din  = 8'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(stall_req), 32'd0);
        check_val("rst_ram_req", 32'(bus.ram_req), 32'd0);
        check_val("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check_val("rst_wb_wdata", wb_wdata, 32'd0);
        check_val("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_txn(2'd0, 1'b0, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 1'b1, 0, -1, 0);
        run_txn(2'd3, 1'b1, 1'b0, 32'h100, 32'hAABB_CCDD, 5'd7, 1'b1, 0, -1, 0);
        run_txn(2'd3, 1'b0, 1'b0, 32'h100, 32'h0, 5'd8, 1'b1, 0, -1, 0);
        check_val("store_word_readback", wb_wdata, 32'hAABB_CCDD);
        mem_model[32'h20] = 8'h80;
        run_txn(2'd1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd9, 1'b1, 0, -1, 0);
        check_val("lb_signed", wb_wdata, 32'hFFFF_FF80);
        run_txn(2'd1, 1'b0, 1'b0, 32'h20, 32'h0, 5'd9, 1'b1, 0, -1, 0);
        check_val("lb_unsigned", wb_wdata, 32'h0000_0080);
        mem_model[32'h40] = 8'h34;
        mem_model[32'h41] = 8'h12;
        run_txn(2'd2, 1'b0, 1'b1, 32'h40, 32'h0, 5'd10, 1'b1, 0, 1, 3);
        check_val("lh_gap", wb_wdata, 32'h0000_1234);
        run_txn(2'd3, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 5'd11, 1'b1, 0, -1, 0);
        run_txn(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'h1122_3344, 5'd12, 1'b1, 1, -1, 0);
        run_txn(2'd3, 1'b0, 1'b0, 32'h102, 32'h0, 5'd13, 1'b1, 0, -1, 0);

        // Reset in the second ACCESS cycle of a word load.
        in_memcnf    = 2'd3;
        in_memwr     = 1'b0;
        in_memaddr   = 32'h200;
        in_memsigned = 1'b0;
        in_wd        = 5'd14;
        in_wreg      = 1'b1;
        bus.ram_gnt  = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_val("abort_ram_req", 32'(bus.ram_req), 32'd0);
        tick();
        #1;
        check_val("post_rst_ram_req", 32'(bus.ram_req), 32'd0);
        check_val("post_rst_stall", 32'(stall_req), 32'd0);
        check_val("post_rst_wb_wd", 32'(wb_wd), 32'd0);
        check_val("post_rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check_val("post_rst_wb_wdata", wb_wdata, 32'd0);
        check_val("post_rst_wb_inst", wb_inst, 32'd0);
        rst         = 1'b0;
        in_memcnf   = 2'd0;
        bus.ram_gnt = 1'b0;
        rd_pend_tb  = 1'b0;
        #1;
        check_val("post_rst_idle_stall", 32'(stall_req), 32'd0);
        run_txn(2'd3, 1'b0, 1'b0, 32'h200, 32'h0, 5'd14, 1'b1, 0, -1, 0);

        // Randomised mix.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                            : (32'h300 + 32'($urandom_range(0, 31)));
            run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)), 1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
